fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem addressing, IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 6,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_a,
  input  logic [31:0]        imem_rd,
  output logic [31:0]        pc,
  output logic [31:0]        instr_d,
  output logic [31:0]        pcplus4_d,
  output logic               valid_d,
  output logic               halted,
  output logic               fault
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [31:0] LAST_PC = (32'd4 << IMEM_AW) - 32'd4;

  state_t      state, state_n;
  logic [31:0] pc_n, instr_n, pcplus4_n;
  logic        valid_n, halted_n, fault_n;
  logic        at_end, at_end_n;
  logic [31:0] pc_plus4;
  logic        redirect_bad;
  logic        at_last;

  assign imem_a       = pc[IMEM_AW+1:2];
  assign pc_plus4     = pc + 32'd4;
  assign at_last      = (pc == LAST_PC);
  assign redirect_bad = (|redirect_pc[1:0]) || (|redirect_pc[31:IMEM_AW+2]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      instr_d   <= 32'd0;
      pcplus4_d <= 32'd0;
      valid_d   <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      at_end    <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr_d   <= instr_n;
      pcplus4_d <= pcplus4_n;
      valid_d   <= valid_n;
      halted    <= halted_n;
      fault     <= fault_n;
      at_end    <= at_end_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    instr_n   = instr_d;
    pcplus4_n = pcplus4_d;
    valid_n   = valid_d;
    halted_n  = halted;
    fault_n   = fault;
    at_end_n  = at_end;

    case (state)
      BOOT: begin
        state_n = RUN;
        valid_n = 1'b0;
      end
      RUN: begin
        if (redirect) begin
          if (redirect_bad) begin
            state_n  = HALT;
            halted_n = 1'b1;
            fault_n  = 1'b1;
            valid_n  = 1'b0;
            instr_n  = 32'd0;
          end else begin
            pc_n     = redirect_pc;
            instr_n  = 32'd0;
            valid_n  = 1'b0;
            at_end_n = 1'b0;
          end
        end else if (stall) begin
          if (flush) begin
            instr_n = 32'd0;
            valid_n = 1'b0;
          end
        end else if (at_end || (flush && at_last)) begin
          // the sequential successor of the last word does not exist
          state_n  = HALT;
          halted_n = 1'b1;
          fault_n  = 1'b1;
          valid_n  = 1'b0;
          instr_n  = 32'd0;
        end else if (flush) begin
          pc_n    = pc_plus4;
          instr_n = 32'd0;
          valid_n = 1'b0;
        end else if (imem_rd == HALT_WORD) begin
          state_n  = HALT;
          halted_n = 1'b1;
          valid_n  = 1'b0;
          instr_n  = 32'd0;
        end else begin
          instr_n   = imem_rd;
          pcplus4_n = pc_plus4;
          valid_n   = 1'b1;
          // at the last word pc parks there and faults on the next fetch
          if (at_last) at_end_n = 1'b1;
          else         pc_n     = pc_plus4;
        end
      end
      HALT: begin
        valid_n  = 1'b0;
        halted_n = 1'b1;
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - vector table with expected-result queue for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [5:0]  imem_a;
  logic [31:0] imem_rd;
  logic [31:0] pc, instr_d, pcplus4_d;
  logic        valid_d, halted, fault;

  logic [31:0] mem [64];
  assign imem_rd = mem[imem_a];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_a(imem_a),
    .imem_rd(imem_rd), .pc(pc), .instr_d(instr_d), .pcplus4_d(pcplus4_d),
    .valid_d(valid_d), .halted(halted), .fault(fault)
  );

  typedef struct {
    bit          rst;
    logic        st, fl, rd;
    logic [31:0] rpc;
    logic [31:0] e_pc, e_instr, e_p4;
    logic        e_valid, e_halted, e_fault;
    bit          chk_instr;
  } vec_t;

  vec_t vecs [$];
  vec_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(bit rst, logic st, logic fl, logic rd, logic [31:0] rpc,
                             logic [31:0] epc, logic [31:0] ei, logic [31:0] ep4,
                             logic ev, logic eh, logic ef, bit ci);
    vec_t r;
    r.rst = rst; r.st = st; r.fl = fl; r.rd = rd; r.rpc = rpc;
    r.e_pc = epc; r.e_instr = ei; r.e_p4 = ep4;
    r.e_valid = ev; r.e_halted = eh; r.e_fault = ef; r.chk_instr = ci;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_reset_values(int idx);
    chk("rst_pc", idx, pc, 32'h0);
    chk("rst_imem_a", idx, {26'd0, imem_a}, 32'h0);
    chk("rst_instr", idx, instr_d, 32'h0);
    chk("rst_pcplus4", idx, pcplus4_d, 32'h0);
    chk("rst_valid", idx, {31'd0, valid_d}, 32'h0);
    chk("rst_halted", idx, {31'd0, halted}, 32'h0);
    chk("rst_fault", idx, {31'd0, fault}, 32'h0);
  endtask

  task automatic apply(int idx, vec_t t);
    vec_t e;
    if (t.rst) begin
      // asynchronous pulse well away from any clock edge
      #3 reset = 1'b1;
      #1 chk_reset_values(idx);
      reset = 1'b0;
    end
    stall = t.st; flush = t.fl; redirect = t.rd; redirect_pc = t.rpc;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
    end else begin
      e = exp_q.pop_front();
      chk("pc", idx, pc, e.e_pc);
      chk("imem_a", idx, {26'd0, imem_a}, {26'd0, e.e_pc[7:2]});
      if (e.chk_instr) chk("instr_d", idx, instr_d, e.e_instr);
      chk("pcplus4_d", idx, pcplus4_d, e.e_p4);
      chk("valid_d", idx, {31'd0, valid_d}, {31'd0, e.e_valid});
      chk("halted", idx, {31'd0, halted}, {31'd0, e.e_halted});
      chk("fault", idx, {31'd0, fault}, {31'd0, e.e_fault});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0007;
    mem[3] = 32'hFFFF_FFFF;

    //             rst st fl rd rpc          pc          instr         p4         v  h  f  ci
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h00, 32'h0,         32'h00,  0, 0, 0, 1)); // BOOT bubble
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h04, 32'h2008_0005, 32'h04,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h08, 32'h2009_0007, 32'h08,  1, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,   32'h08, 32'h2009_0007, 32'h08,  1, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 0, 32'h0,   32'h08, 32'h2009_0007, 32'h08,  1, 0, 0, 1));
    vecs.push_back(v(0, 1, 1, 0, 32'h0,   32'h08, 32'h0,         32'h08,  0, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 1, 32'h40,  32'h40, 32'h0,         32'h08,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h44, 32'h1000_0010, 32'h44,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 32'h0,   32'h48, 32'h0,         32'h44,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h4C, 32'h1000_0012, 32'h4C,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 32'h0,   32'h00, 32'h0,         32'h4C,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h04, 32'h2008_0005, 32'h04,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h08, 32'h2009_0007, 32'h08,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h0C, 32'h1000_0002, 32'h0C,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h0C, 32'h0,         32'h0C,  0, 1, 0, 1)); // halt word
    vecs.push_back(v(0, 0, 0, 1, 32'h0,   32'h0C, 32'h0,         32'h0C,  0, 1, 0, 1));
    vecs.push_back(v(0, 1, 1, 0, 32'h0,   32'h0C, 32'h0,         32'h0C,  0, 1, 0, 1));
    vecs.push_back(v(1, 0, 0, 0, 32'h0,   32'h00, 32'h0,         32'h00,  0, 0, 0, 1)); // reset in HALT
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h04, 32'h2008_0005, 32'h04,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 32'h42,  32'h04, 32'h0,         32'h04,  0, 1, 1, 0)); // misaligned
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'h04, 32'h0,         32'h04,  0, 1, 1, 0));
    vecs.push_back(v(1, 0, 0, 0, 32'h0,   32'h00, 32'h0,         32'h00,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 32'h100, 32'h00, 32'h0,         32'h00,  0, 1, 1, 0)); // out of range
    vecs.push_back(v(1, 0, 0, 0, 32'h0,   32'h00, 32'h0,         32'h00,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 32'hF8,  32'hF8, 32'h0,         32'h00,  0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'hFC, 32'h1000_003E, 32'hFC,  1, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'hFC, 32'h1000_003F, 32'h100, 1, 0, 0, 1)); // last word
    vecs.push_back(v(0, 0, 0, 0, 32'h0,   32'hFC, 32'h0,         32'h100, 0, 1, 1, 0)); // end fault
    vecs.push_back(v(0, 0, 0, 1, 32'h0,   32'hFC, 32'h0,         32'h100, 0, 1, 1, 0));

    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(posedge clk);
    #1 chk_reset_values(-1);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // hand sequence: reset held across a clock edge keeps everything cleared
    #2 reset = 1'b1;
    @(posedge clk);
    #1 chk_reset_values(100);
    reset = 1'b0;
    apply(101, v(0, 0, 0, 0, 32'h0, 32'h00, 32'h0,         32'h00, 0, 0, 0, 1));
    apply(102, v(0, 0, 0, 0, 32'h0, 32'h04, 32'h2008_0005, 32'h04, 1, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
